// File: rtl/irq_request_latch.sv
// Sticky request latch feeding priority_encoder_8_3: captures request events,
// masks them onto pend_out and runs the irq/ack handshake FSM.
module irq_request_latch #(
  parameter bit         EDGE_MODE = 1'b1,
  parameter logic [7:0] MASK_RST  = 8'h00
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] req_in,
  input  logic       mask_wr,
  input  logic [7:0] mask_in,
  input  logic       ack,
  input  logic [2:0] ack_idx,
  input  logic       clear_lost,
  output logic [7:0] pend_out,
  output logic       irq,
  output logic [7:0] mask_out,
  output logic [7:0] lost
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ASSERT = 2'd1,
    ST_CLEAR  = 2'd2
  } state_t;

  state_t     state_q, state_d;
  logic [7:0] req_q, req_d;
  logic [7:0] pending_q, pending_d;
  logic [7:0] mask_q, mask_d;
  logic [7:0] lost_q, lost_d;
  logic [7:0] ev_s;
  logic [7:0] clr_vec_s;
  logic [7:0] lost_set_s;

  // Event detection, retire vector and next values of the datapath registers.
  always_comb begin
    req_d = req_in;
    if (EDGE_MODE) begin
      ev_s = req_in & ~req_q;
    end else begin
      ev_s = req_in;
    end
    if ((state_q == ST_ASSERT) && ack) begin
      clr_vec_s = 8'h01 << ack_idx;
    end else begin
      clr_vec_s = 8'h00;
    end
    // A new event on a line being retired re-pends it without counting as lost.
    pending_d = (pending_q & ~clr_vec_s) | ev_s;
    if (EDGE_MODE) begin
      lost_set_s = ev_s & pending_q & ~clr_vec_s;
    end else begin
      lost_set_s = 8'h00;
    end
    if (clear_lost) begin
      lost_d = lost_set_s;
    end else begin
      lost_d = lost_q | lost_set_s;
    end
    if (mask_wr) begin
      mask_d = mask_in;
    end else begin
      mask_d = mask_q;
    end
  end

  // Datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      req_q     <= req_in;
      pending_q <= 8'h00;
      mask_q    <= MASK_RST;
      lost_q    <= 8'h00;
    end else begin
      req_q     <= req_d;
      pending_q <= pending_d;
      mask_q    <= mask_d;
      lost_q    <= lost_d;
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state; CLEAR always returns to IDLE to force an irq-low gap.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (pend_out != 8'h00) begin
          state_d = ST_ASSERT;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ASSERT: begin
        if (ack) begin
          state_d = ST_CLEAR;
        end else if (pend_out == 8'h00) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_ASSERT;
        end
      end
      ST_CLEAR: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Outputs decoded from registers only.
  always_comb begin
    pend_out = pending_q & mask_q;
    irq      = (state_q == ST_ASSERT);
    mask_out = mask_q;
    lost     = lost_q;
  end

endmodule

// File: tb/tb_irq_request_latch.sv
// Directed bench for irq_request_latch: edge-mode instance with MASK_RST=FF
// plus a level-mode instance for the hold-high re-pend case.
module tb_irq_request_latch;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] req_in;
  logic       mask_wr;
  logic [7:0] mask_in;
  logic       ack;
  logic [2:0] ack_idx;
  logic       clear_lost;

  logic [7:0] pend_out, mask_out, lost;
  logic       irq;
  logic [7:0] pend_out_l, mask_out_l, lost_l;
  logic       irq_l;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  irq_request_latch #(.EDGE_MODE(1'b1), .MASK_RST(8'hFF)) dut (
    .clk(clk), .rst(rst), .req_in(req_in), .mask_wr(mask_wr), .mask_in(mask_in),
    .ack(ack), .ack_idx(ack_idx), .clear_lost(clear_lost),
    .pend_out(pend_out), .irq(irq), .mask_out(mask_out), .lost(lost)
  );

  irq_request_latch #(.EDGE_MODE(1'b0), .MASK_RST(8'h00)) dut_lvl (
    .clk(clk), .rst(rst), .req_in(req_in), .mask_wr(mask_wr), .mask_in(mask_in),
    .ack(ack), .ack_idx(ack_idx), .clear_lost(clear_lost),
    .pend_out(pend_out_l), .irq(irq_l), .mask_out(mask_out_l), .lost(lost_l)
  );

  task automatic check_eq(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %02h expected %02h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic write_mask(input logic [7:0] m);
    mask_wr = 1'b1;
    mask_in = m;
    step();
    mask_wr = 1'b0;
  endtask

  initial begin
    rst = 1'b1; req_in = 8'hFF; mask_wr = 1'b0; mask_in = 8'h00;
    ack = 1'b0; ack_idx = 3'd0; clear_lost = 1'b0;

    // 1: lines high through reset release create no events
    step(); step();
    rst = 1'b0;
    check_eq("t1_mask_rst", mask_out, 8'hFF);
    for (int i = 0; i < 4; i++) begin
      step();
      check_eq("t1_pend", pend_out, 8'h00);
      check_eq("t1_irq", {7'd0, irq}, 8'h00);
    end
    check_eq("t1_lost", lost, 8'h00);
    req_in = 8'h00; step();

    // 2: single pulse on line 5
    req_in = 8'h20; step();
    check_eq("t2_pend_e0", pend_out, 8'h20);
    check_eq("t2_irq_e0", {7'd0, irq}, 8'h00);
    req_in = 8'h00; step();
    check_eq("t2_irq_e1", {7'd0, irq}, 8'h01);
    ack = 1'b1; ack_idx = 3'd5; step();
    ack = 1'b0;
    check_eq("t2_pend_ack", pend_out, 8'h00);
    check_eq("t2_irq_ack", {7'd0, irq}, 8'h00);
    step(); step();
    check_eq("t2_irq_idle", {7'd0, irq}, 8'h00);

    // 3: two lines, retire 6, line 1 re-asserts after gap
    req_in = 8'h42; step();
    check_eq("t3_pend", pend_out, 8'h42);
    req_in = 8'h00; step();
    check_eq("t3_irq", {7'd0, irq}, 8'h01);
    ack = 1'b1; ack_idx = 3'd6; step();
    ack = 1'b0;
    check_eq("t3_irq_clear", {7'd0, irq}, 8'h00);
    check_eq("t3_pend_left", pend_out, 8'h02);
    step();
    check_eq("t3_irq_gap", {7'd0, irq}, 8'h00);
    step();
    check_eq("t3_irq_reassert", {7'd0, irq}, 8'h01);
    ack = 1'b1; ack_idx = 3'd1; step();
    ack = 1'b0; step(); step();
    check_eq("t3_pend_empty", pend_out, 8'h00);

    // 4: masked event becomes visible once enabled
    write_mask(8'h00);
    check_eq("t4_mask", mask_out, 8'h00);
    req_in = 8'h08; step();
    check_eq("t4_pend_masked", pend_out, 8'h00);
    req_in = 8'h00; step();
    check_eq("t4_irq_masked", {7'd0, irq}, 8'h00);
    write_mask(8'h08);
    check_eq("t4_pend_unmask", pend_out, 8'h08);
    check_eq("t4_irq_unmask", {7'd0, irq}, 8'h00);
    step();
    check_eq("t4_irq_late", {7'd0, irq}, 8'h01);
    // removing the mask drops ASSERT back to IDLE without ack
    write_mask(8'h00);
    check_eq("t4_pend_remask", pend_out, 8'h00);
    step();
    check_eq("t4_irq_drop", {7'd0, irq}, 8'h00);
    // ack in IDLE must not retire the still-pending line 3
    ack = 1'b1; ack_idx = 3'd3; step();
    ack = 1'b0;
    write_mask(8'hFF);
    check_eq("t4_ack_idle_ignored", pend_out, 8'h08);
    step();
    ack = 1'b1; ack_idx = 3'd3; step();
    ack = 1'b0; step(); step();
    check_eq("t4_pend_empty", pend_out, 8'h00);

    // 5: lost tracking, clear_lost, set-vs-ack collision
    req_in = 8'h04; step();
    check_eq("t5_pend", pend_out, 8'h04);
    req_in = 8'h00; step();
    check_eq("t5_irq", {7'd0, irq}, 8'h01);
    req_in = 8'h04; step();
    check_eq("t5_lost", lost, 8'h04);
    req_in = 8'h00; clear_lost = 1'b1; step();
    clear_lost = 1'b0;
    check_eq("t5_lost_clr", lost, 8'h00);
    req_in = 8'h04; ack = 1'b1; ack_idx = 3'd2; step();
    req_in = 8'h00; ack = 1'b0;
    check_eq("t5_set_wins", pend_out, 8'h04);
    check_eq("t5_no_lost", lost, 8'h00);
    check_eq("t5_irq_clear", {7'd0, irq}, 8'h00);
    step();
    check_eq("t5_irq_gap", {7'd0, irq}, 8'h00);
    step();
    check_eq("t5_irq_reassert", {7'd0, irq}, 8'h01);

    // 6: level mode, held line re-pends through the handshake
    rst = 1'b1; req_in = 8'h00; step();
    rst = 1'b0;
    check_eq("t6_rst_pend", pend_out_l, 8'h00);
    check_eq("t6_rst_mask", mask_out_l, 8'h00);
    write_mask(8'hFF);
    req_in = 8'h01; step();
    check_eq("t6_pend", pend_out_l, 8'h01);
    check_eq("t6_irq_e0", {7'd0, irq_l}, 8'h00);
    step();
    check_eq("t6_irq_assert", {7'd0, irq_l}, 8'h01);
    ack = 1'b1; ack_idx = 3'd0; step();
    ack = 1'b0;
    check_eq("t6_irq_clear", {7'd0, irq_l}, 8'h00);
    check_eq("t6_repend", pend_out_l, 8'h01);
    step();
    check_eq("t6_irq_idle", {7'd0, irq_l}, 8'h00);
    step();
    check_eq("t6_irq_reassert", {7'd0, irq_l}, 8'h01);
    check_eq("t6_lost", lost_l, 8'h00);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
